// File: rtl/mux_operand_bank.sv
// ---------------------------------------------------------------------------
// mux_operand_bank
//
// Small register bank that feeds the two operands (a, b) of the processor's
// 2:1 operand multiplexer. Both read ports are registered so the mux sees
// stable operands for a full cycle. The single write port forwards its data
// straight to a read port that addresses the same register in the same cycle,
// so a freshly produced value reaches the mux without a stall.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - synchronous active-low reset; clears the bank and outputs
//   wr_en      - write request for this cycle
//   wr_addr    - register written when wr_en=1
//   wr_data    - data written when wr_en=1
//   rd_en      - read request; captures both operands this cycle
//   rd_addr_a  - register feeding operand a
//   rd_addr_b  - register feeding operand b
//   out_a      - registered operand a
//   out_b      - registered operand b
//   out_valid  - high for exactly the cycle after an accepted read
// ---------------------------------------------------------------------------
module mux_operand_bank #(
    parameter int DATA_W = 8,
    parameter int N_REGS = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid
);

    // Register array held as plain flops.
    logic [DATA_W-1:0] regs [N_REGS];

    // Read-port values after bypass selection.
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;

    // Bypass: a same-cycle write to the addressed register wins over the
    // stored value, independently for each port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves it unassigned (no latch).
        rd_val_a = regs[rd_addr_a];
        rd_val_b = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_val_a = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_val_b = wr_data;
        end
    end

    // Register bank write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the bank is functional state that must read back as zero
            // after reset, so it is cleared here rather than left to power-up.
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking assignment, so the bypass logic above still
            // sees the old contents during this edge's evaluation.
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports. Operands hold when no read is requested; the
    // valid flag is a one-cycle pulse per accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            if (rd_en) begin
                out_a <= rd_val_a;
                out_b <= rd_val_b;
            end
        end
    end

endmodule

// File: tb/tb_mux_operand_bank.sv
// ---------------------------------------------------------------------------
// tb_mux_operand_bank
//
// Directed scenarios followed by a randomized phase. A behavioural model of
// the bank (an array plus the expected output registers) is updated once per
// clock edge from the same inputs driven to the DUT, and the DUT outputs are
// compared 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_operand_bank;

    localparam int DATA_W = 8;
    localparam int N_REGS = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_valid;

    mux_operand_bank #(
        .DATA_W(DATA_W),
        .N_REGS(N_REGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DATA_W-1:0] mdl_mem [N_REGS];
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    logic              exp_valid;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge: read values come from the bank as it stands
    // before the edge, unless the same edge writes that register.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) mdl_mem[i] = '0;
            exp_a     = '0;
            exp_b     = '0;
            exp_valid = 1'b0;
        end else begin
            if (rd_en) begin
                exp_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : mdl_mem[rd_addr_a];
                exp_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : mdl_mem[rd_addr_b];
            end
            exp_valid = rd_en;
            if (wr_en) mdl_mem[wr_addr] = wr_data;
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cycle(input logic rst, input logic we, input int wa, input logic [7:0] wd,
                         input logic re, input int ra, input int rb);
        rst_n     = rst;
        wr_en     = we;
        wr_addr   = ADDR_W'(wa);
        wr_data   = wd;
        rd_en     = re;
        rd_addr_a = ADDR_W'(ra);
        rd_addr_b = ADDR_W'(rb);
        @(posedge clk);
        model_edge();
        #1;
        check("model_a", 32'(out_a), 32'(exp_a));
        check("model_b", 32'(out_b), 32'(exp_b));
        check("model_valid", 32'(out_valid), 32'(exp_valid));
    endtask

    task automatic write(input int wa, input logic [7:0] wd);
        cycle(1'b1, 1'b1, wa, wd, 1'b0, 0, 0);
    endtask

    task automatic read(input int ra, input int rb);
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b1, ra, rb);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic v);
        check({tag, "_a"}, 32'(out_a), 32'(a));
        check({tag, "_b"}, 32'(out_b), 32'(b));
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        logic [7:0] held_a;
        logic [7:0] held_b;

        for (int i = 0; i < N_REGS; i++) mdl_mem[i] = '0;
        exp_a     = '0;
        exp_b     = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        // Reset held for two cycles while write and read are requested.
        cycle(1'b0, 1'b1, 0, 8'hFF, 1'b1, 0, 1);
        cycle(1'b0, 1'b1, 1, 8'hFF, 1'b1, 0, 1);
        expect_out("reset", 8'h00, 8'h00, 1'b0);
        read(0, 1);
        expect_out("reset_rd01", 8'h00, 8'h00, 1'b1);
        read(2, 3);
        expect_out("reset_rd23", 8'h00, 8'h00, 1'b1);

        // Write then read.
        write(1, 8'b0010_1101);
        write(2, 8'b0010_1110);
        read(1, 2);
        expect_out("wr_rd", 8'b0010_1101, 8'b0010_1110, 1'b1);
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 0);
        expect_out("wr_rd_hold", 8'b0010_1101, 8'b0010_1110, 1'b0);

        // Bypass on port a while port b reads an untouched register.
        write(3, 8'b1011_1001);
        cycle(1'b1, 1'b1, 3, 8'b0011_1000, 1'b1, 3, 0);
        expect_out("bypass", 8'b0011_1000, 8'h00, 1'b1);
        read(3, 3);
        expect_out("bypass_after", 8'b0011_1000, 8'b0011_1000, 1'b1);

        // Bypass on both ports together.
        cycle(1'b1, 1'b1, 1, 8'h5A, 1'b1, 1, 1);
        expect_out("bypass_both", 8'h5A, 8'h5A, 1'b1);

        // Back-to-back reads.
        write(0, 8'b1010_0101);
        write(1, 8'b0100_1110);
        write(2, 8'b0011_1111);
        write(3, 8'b0010_0001);
        read(0, 1);
        expect_out("b2b_0", 8'b1010_0101, 8'b0100_1110, 1'b1);
        read(2, 3);
        expect_out("b2b_1", 8'b0011_1111, 8'b0010_0001, 1'b1);
        read(3, 3);
        expect_out("b2b_2", 8'b0010_0001, 8'b0010_0001, 1'b1);

        // Reset mid-operation discards the pending read.
        write(2, 8'b1111_0000);
        cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 2, 2);
        expect_out("mid_reset", 8'h00, 8'h00, 1'b0);
        read(2, 2);
        expect_out("mid_reset_rd", 8'h00, 8'h00, 1'b1);

        // Randomized phase against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N_REGS - 1)),
                  8'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, N_REGS - 1)),
                  int'($urandom_range(0, N_REGS - 1)));
        end

        // Outputs hold over a run of idle cycles.
        read(1, 3);
        held_a = exp_a;
        held_b = exp_b;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b1, n, 8'($urandom), 1'b0, 0, 0);
            expect_out("idle_hold", held_a, held_b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
